prf_free_list: RTL and testbench

Physical-register free list for the 2-way out-of-order core. It hands up to two free PRF indices per cycle to the dispatch/rename stage. It accepts up to two released PRF indices per cycle from the retirement RAT, which frees the stale mapping when an instruction retires. On a branch mispredict it rolls speculative allocations back to the architectural point in one cycle. Together with the RRAT, this block decides which physical registers are owned.

---
 rtl/ooo_pkg.sv | 15 +
 rtl/prf_free_list.sv | 105 ++++++++++
 tb/tb_prf_free_list.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ooo_pkg.sv
// Shared sizing, index types and small helpers for the 2-way out-of-order core.
package ooo_pkg;

  localparam int PRF_SIZE = 64;
  localparam int ARF_SIZE = 32;
  localparam int WAY      = 2;

  typedef logic [$clog2(PRF_SIZE)-1:0] prf_idx_t;
  typedef logic [$clog2(ARF_SIZE)-1:0] arf_idx_t;

  function automatic logic [1:0] popcount2(input logic [1:0] bits);
    return {1'b0, bits[0]} + {1'b0, bits[1]};
  endfunction

endpackage

// File: rtl/prf_free_list.sv
// Physical-register free list: a ring of free PRF indices with a speculative
// allocation head, an architectural (retired) head and a release tail.
module prf_free_list #(
  parameter int PRF_SIZE = ooo_pkg::PRF_SIZE,
  parameter int ARF_SIZE = ooo_pkg::ARF_SIZE,
  parameter int FL_DEPTH = PRF_SIZE - ARF_SIZE,
  localparam int IDX_W   = $clog2(PRF_SIZE),
  localparam int PTR_W   = $clog2(FL_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            alloc_req,
  output logic [1:0]            alloc_gnt,
  output logic [1:0][IDX_W-1:0] alloc_idx,
  input  logic [1:0]            free_valid,
  input  logic [1:0][IDX_W-1:0] free_idx,
  input  logic [1:0]            commit_valid,
  input  logic                  mispredict_sig,
  output logic [PTR_W-1:0]      free_count,
  output logic                  fl_empty
);

  import ooo_pkg::*;

  localparam int SLOT_W = PTR_W - 1;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [IDX_W-1:0]  fl_mem [FL_DEPTH];
  ptr_t              spec_head;
  ptr_t              arch_head;
  ptr_t              tail;
  logic [SLOT_W-1:0] head_slot;
  logic [SLOT_W-1:0] head_slot_p1;
  logic [SLOT_W-1:0] tail_slot;
  logic [SLOT_W-1:0] tail_slot_p1;
  logic [1:0]        n_req;
  logic [1:0]        n_gnt;
  logic [1:0]        n_free;
  logic [1:0]        n_commit;
  logic              grant_ok;
  ptr_t              arch_span;
  ptr_t              spec_span;

  assign n_req    = popcount2(alloc_req);
  assign n_gnt    = popcount2(alloc_gnt);
  assign n_free   = popcount2(free_valid);
  assign n_commit = popcount2(commit_valid);

  assign head_slot    = spec_head[SLOT_W-1:0];
  assign head_slot_p1 = head_slot + SLOT_W'(1);
  assign tail_slot    = tail[SLOT_W-1:0];
  assign tail_slot_p1 = tail_slot + SLOT_W'(1);

  assign free_count = tail - spec_head;
  assign fl_empty   = (free_count == '0);

  // Grants are all-or-nothing and forced off while reset is held, so the
  // outputs show reset values without waiting for an edge.
  assign grant_ok  = reset && !mispredict_sig && (ptr_t'(n_req) <= free_count);
  assign alloc_gnt = grant_ok ? alloc_req : 2'b00;

  // A lone request on way1 takes the head entry; otherwise way1 takes head+1.
  always_comb begin
    alloc_idx    = '0;
    alloc_idx[0] = fl_mem[head_slot];
    alloc_idx[1] = (alloc_req == 2'b10) ? fl_mem[head_slot] : fl_mem[head_slot_p1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_mem[i] <= IDX_W'(ARF_SIZE + i);
      end
      spec_head <= '0;
      arch_head <= '0;
      tail      <= ptr_t'(FL_DEPTH);
    end else begin
      if (free_valid[0]) begin
        fl_mem[tail_slot] <= free_idx[0];
      end
      if (free_valid[1]) begin
        fl_mem[free_valid[0] ? tail_slot_p1 : tail_slot] <= free_idx[1];
      end
      tail      <= tail + ptr_t'(n_free);
      arch_head <= arch_head + ptr_t'(n_commit);
      // Recovery lands on the retired point including this cycle's commits.
      if (mispredict_sig) begin
        spec_head <= arch_head + ptr_t'(n_commit);
      end else begin
        spec_head <= spec_head + ptr_t'(n_gnt);
      end
    end
  end

  assign arch_span = tail - arch_head;
  assign spec_span = spec_head - arch_head;

  a_no_free_overflow: assert property (
    @(posedge clock) disable iff (!reset) arch_span <= ptr_t'(FL_DEPTH));

  a_no_commit_past_spec: assert property (
    @(posedge clock) disable iff (!reset) ptr_t'(n_commit) <= spec_span);

endmodule

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list with hand-computed expected values.
module tb_prf_free_list;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      alloc_req;
  logic [1:0]      alloc_gnt;
  logic [1:0][5:0] alloc_idx;
  logic [1:0]      free_valid;
  logic [1:0][5:0] free_idx;
  logic [1:0]      commit_valid;
  logic            mispredict_sig;
  logic [5:0]      free_count;
  logic            fl_empty;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;

  prf_free_list dut (
    .clock          (clock),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_gnt      (alloc_gnt),
    .alloc_idx      (alloc_idx),
    .free_valid     (free_valid),
    .free_idx       (free_idx),
    .commit_valid   (commit_valid),
    .mispredict_sig (mispredict_sig),
    .free_count     (free_count),
    .fl_empty       (fl_empty)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] fv,
                               input logic [5:0] i0, input logic [5:0] i1,
                               input logic [1:0] cv, input logic misp);
    alloc_req      = req;
    free_valid     = fv;
    free_idx[0]    = i0;
    free_idx[1]    = i1;
    commit_valid   = cv;
    mispredict_sig = misp;
    #1;
  endtask

  task automatic tickClock();
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    tickClock();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    resetDut();

    // Reset state
    checkOutput("rst_free_count", 32'(free_count), 32);
    checkOutput("rst_idx0", 32'(alloc_idx[0]), 32);
    checkOutput("rst_idx1", 32'(alloc_idx[1]), 33);
    checkOutput("rst_gnt", 32'(alloc_gnt), 0);
    checkOutput("rst_empty", 32'(fl_empty), 0);

    // Drain the whole list two at a time
    for (int k = 0; k < 16; k++) begin
      applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
      checkOutput("drain_gnt", 32'(alloc_gnt), 3);
      checkOutput("drain_idx0", 32'(alloc_idx[0]), 32'(32 + 2 * k));
      checkOutput("drain_idx1", 32'(alloc_idx[1]), 32'(33 + 2 * k));
      tickClock();
    end
    applyStimulus(2'b01, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    checkOutput("empty_count", 32'(free_count), 0);
    checkOutput("empty_flag", 32'(fl_empty), 1);
    checkOutput("empty_gnt", 32'(alloc_gnt), 0);

    // Retire everything so later releases stay within capacity
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 2'b11, 1'b0);
    repeat (16) tickClock();

    // Free from empty: no same-cycle bypass
    applyStimulus(2'b01, 2'b01, 6'd5, 6'd0, 2'b00, 1'b0);
    checkOutput("nobypass_gnt", 32'(alloc_gnt), 0);
    tickClock();
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    checkOutput("one_free_count", 32'(free_count), 1);
    checkOutput("one_free_req11_gnt", 32'(alloc_gnt), 0);
    applyStimulus(2'b10, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    checkOutput("one_free_req10_gnt", 32'(alloc_gnt), 2);
    checkOutput("one_free_idx1", 32'(alloc_idx[1]), 5);
    tickClock();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    checkOutput("refill_used_count", 32'(free_count), 0);

    // Mispredict rolls back to the retired point
    resetDut();
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    repeat (2) tickClock();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 2'b11, 1'b0);
    tickClock();
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b1);
    checkOutput("misp_gnt", 32'(alloc_gnt), 0);
    tickClock();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    checkOutput("misp_count", 32'(free_count), 30);
    checkOutput("misp_idx0", 32'(alloc_idx[0]), 34);

    // Mispredict with same-cycle commit and frees
    resetDut();
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    repeat (2) tickClock();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 2'b01, 1'b0);
    tickClock();
    applyStimulus(2'b00, 2'b11, 6'd2, 6'd4, 2'b01, 1'b1);
    tickClock();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    checkOutput("misp_free_count", 32'(free_count), 32);
    checkOutput("misp_free_idx0", 32'(alloc_idx[0]), 34);
    for (int k = 0; k < 15; k++) begin
      applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
      checkOutput("wrap_idx0", 32'(alloc_idx[0]), 32'(34 + 2 * k));
      checkOutput("wrap_idx1", 32'(alloc_idx[1]), 32'(35 + 2 * k));
      tickClock();
    end
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    checkOutput("wrap_last_gnt", 32'(alloc_gnt), 3);
    checkOutput("wrap_last_idx0", 32'(alloc_idx[0]), 2);
    checkOutput("wrap_last_idx1", 32'(alloc_idx[1]), 4);
    tickClock();
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    checkOutput("wrap_empty", 32'(fl_empty), 1);

    // Asynchronous reset in the middle of a cycle
    resetDut();
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    tickClock();
    applyStimulus(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    checkOutput("pre_areset_gnt", 32'(alloc_gnt), 3);
    checkOutput("pre_areset_count", 32'(free_count), 30);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("areset_gnt", 32'(alloc_gnt), 0);
    checkOutput("areset_count", 32'(free_count), 32);
    checkOutput("areset_idx0", 32'(alloc_idx[0]), 32);
    checkOutput("areset_idx1", 32'(alloc_idx[1]), 33);
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
